// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   arb_state_t : arbiter FSM state (IDLE / GRANT)
//   idx_w()     : index width for an N-entry vector (at least 1 bit)
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_ctrl_pick.sv
// rr_pick: combinational rotate-and-priority-encode.
//   req      : request vector
//   ptr      : first index searched (search wraps mod N)
//   mask_idx : index excluded from the search when mask_en is high
//   mask_en  : enable for mask_idx exclusion
//   found    : some eligible request exists
//   idx      : index of the first eligible request at or after ptr
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = idx_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic [IDW-1:0] mask_idx,
  input  logic           mask_en,
  output logic           found,
  output logic [IDW-1:0] idx
);

  // One extra bit so ptr+k (< 2N) can be reduced mod N by a single subtract.
  logic [IDW:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(N)) pos = pos - (IDW+1)'(N);
      if (!found && req[pos[IDW-1:0]] &&
          !(mask_en && (pos[IDW-1:0] == mask_idx))) begin
        found = 1'b1;
        idx   = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: N-requester round-robin arbiter with bounded tenure.
//   clk, rst_n : clock, async active-low reset
//   req        : level-sensitive request vector
//   gnt        : registered one-hot grant (zero when idle)
//   gnt_id     : index of current owner (0 when idle), datapath mux select
//   gnt_valid  : |gnt
//   preempt    : one-cycle pulse on the first cycle of a new owner that
//                took over because the previous owner's tenure expired
module rr_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = idx_w(N),
  localparam int HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           preempt
);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   gnt_d;
  logic [IDW-1:0] id_d;
  logic           pre_d;

  logic           found;
  logic [IDW-1:0] pick_idx;
  logic           expiry;
  logic           take;
  logic           take_pre;

  // While someone owns the grant the owner is always excluded; on a release
  // its req bit is already low, so the mask only matters at tenure expiry.
  rr_pick #(.N(N)) u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .mask_idx (gnt_id),
    .mask_en  (state_q == GRANT),
    .found    (found),
    .idx      (pick_idx)
  );

  assign expiry    = (hold_q == HW'(MAX_HOLD - 1));
  assign gnt_valid = |gnt;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt;
    id_d     = gnt_id;
    pre_d    = 1'b0;
    take     = 1'b0;
    take_pre = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) take = 1'b1;
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          // Release wins over a coincident expiry: no preempt pulse.
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (!expiry) begin
          hold_d = hold_q + HW'(1);
        end else if (found) begin
          take     = 1'b1;
          take_pre = 1'b1;
        end else begin
          // Nobody waiting: owner keeps the grant with a fresh tenure.
          hold_d = '0;
        end
      end
      default: ;
    endcase

    if (take) begin
      state_d         = GRANT;
      gnt_d           = '0;
      gnt_d[pick_idx] = 1'b1;
      id_d            = pick_idx;
      hold_d          = '0;
      ptr_d           = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
      pre_d           = take_pre;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      preempt <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt     <= gnt_d;
      gnt_id  <= id_d;
      preempt <= pre_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Self-checking bench for rr_arbiter_ctrl (N=4, MAX_HOLD=4): a hand-derived
// vector table, hand-written reset corner cases, and random requests checked
// against a behavioural owner/tenure model.
module tb_rr_arbiter_ctrl;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;
  logic         preempt;

  int errors = 0;
  int checks = 0;

  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         pre;
  } vec_t;

  vec_t tbl[24];

  // Behavioural model: owner index (-1 = idle), cycles held so far, search start.
  int   m_owner;
  int   m_ten;
  int   m_ptr;
  logic m_pre;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh2id(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic chk_out(input string tag, input logic [N-1:0] eg, input logic ep);
    chk({tag, " gnt"},       32'(gnt),       32'(eg));
    chk({tag, " gnt_id"},    32'(gnt_id),    32'(oh2id(eg)));
    chk({tag, " gnt_valid"}, 32'(gnt_valid), 32'(eg != '0));
    chk({tag, " preempt"},   32'(preempt),   32'(ep));
  endtask

  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", '0, 1'b0);
    rst_n = 1'b1;
  endtask

  function automatic int scan(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r);
    int w;
    m_pre = 1'b0;
    if (m_owner < 0 || !r[m_owner]) begin
      w = scan(r, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_ten = 1; m_ptr = (w + 1) % N;
      end else begin
        m_owner = -1; m_ten = 0;
      end
    end else if (m_ten < MH) begin
      m_ten++;
    end else begin
      w = scan(r, m_ptr, m_owner);
      if (w >= 0) begin
        m_owner = w; m_ten = 1; m_ptr = (w + 1) % N; m_pre = 1'b1;
      end else begin
        m_ten = 1;
      end
    end
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] eg;

    // {req applied before edge, expected gnt after edge, expected preempt}
    tbl[0]  = '{4'b0100, 4'b0100, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0100, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0100, 1'b0};
    tbl[4]  = '{4'b0100, 4'b0100, 1'b0}; // expiry, no contender
    tbl[5]  = '{4'b1111, 4'b0100, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0100, 1'b0};
    tbl[7]  = '{4'b1111, 4'b0100, 1'b0};
    tbl[8]  = '{4'b1111, 4'b1000, 1'b1}; // preempt 2 -> 3
    tbl[9]  = '{4'b1111, 4'b1000, 1'b0};
    tbl[10] = '{4'b1111, 4'b1000, 1'b0};
    tbl[11] = '{4'b1111, 4'b1000, 1'b0};
    tbl[12] = '{4'b1111, 4'b0001, 1'b1}; // preempt 3 -> 0 (wrap)
    tbl[13] = '{4'b0010, 4'b0010, 1'b0}; // release handoff
    tbl[14] = '{4'b1010, 4'b0010, 1'b0};
    tbl[15] = '{4'b1100, 4'b0100, 1'b0};
    tbl[16] = '{4'b1001, 4'b1000, 1'b0}; // ptr=3 after granting 2
    tbl[17] = '{4'b0001, 4'b0001, 1'b0}; // wrap to 0
    tbl[18] = '{4'b0000, 4'b0000, 1'b0}; // idle
    tbl[19] = '{4'b0010, 4'b0010, 1'b0};
    tbl[20] = '{4'b0010, 4'b0010, 1'b0};
    tbl[21] = '{4'b0010, 4'b0010, 1'b0};
    tbl[22] = '{4'b0010, 4'b0010, 1'b0};
    tbl[23] = '{4'b0100, 4'b0100, 1'b0}; // release coincident with expiry

    req   = '0;
    rst_n = 1'b0;
    #2;
    chk_out("async_reset_initial", '0, 1'b0);
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].req);
      chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].pre);
    end

    // Async reset mid-grant, then restart with ptr back at 0.
    do_reset();
    step(4'b0100);
    chk_out("pre_rst_a", 4'b0100, 1'b0);
    step(4'b0010);
    chk_out("pre_rst_b", 4'b0010, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid_grant", '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1001;
    #1;
    chk_out("latency_before_edge", '0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("restart_ptr0", 4'b0001, 1'b0);

    // Random stimulus against the model.
    do_reset();
    m_owner = -1; m_ten = 0; m_ptr = 0; m_pre = 1'b0;
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      else if ($urandom_range(0, 7) == 0) r[$urandom_range(0, N-1)] ^= 1'b1;
      model_step(r);
      step(r);
      eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
      chk_out("rand", eg, m_pre);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_ctrl.md
Name: rr_arbiter_ctrl

Overview:
- N-requester round-robin arbiter FSM that shares one downstream resource between requesters.
- Grant is registered and held while the owner keeps requesting, bounded by a maximum tenure (MAX_HOLD cycles); on expiry the owner is preempted if another requester is waiting.
- Sits between requester ports and the shared datapath; gnt_id drives the datapath mux select.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner before preemption (1..255).
- IDW, $clog2(N), width of gnt_id (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, level-sensitive, bit i = requester i.
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- gnt_id  output  IDW  index of current owner; 0 when idle.
- gnt_valid  output  1  high iff gnt is non-zero.
- preempt  output  1  one-cycle pulse, registered, coincident with the first grant cycle of the new owner after a tenure-expiry handoff.

Behaviour:
- Reset: gnt=0, gnt_id=0, gnt_valid=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0.
- ptr: lowest-priority-search start index; the winner is the first set req bit scanning ptr, ptr+1, ..., wrapping mod N.
- On every grant to index i (new or re-granted), ptr <= (i+1) mod N; wrap from N-1 goes to 0.
- IDLE:
  - req==0 -> stay.
  - Otherwise pick winner w from req sampled at edge t; gnt[w]=1 from edge t+1 (1-cycle latency); hold_cnt=0; -> GRANT.
- GRANT (owner o):
  - req[o]=1 and hold_cnt<MAX_HOLD-1 -> keep grant, hold_cnt++.
  - req[o]=0 (release): if any other req, hand off at the same edge to the next winner (no idle bubble), hold_cnt=0, preempt=0. Else -> IDLE, gnt=0.
  - req[o]=1 and hold_cnt==MAX_HOLD-1 (expiry):
    - If any req[j], j!=o, grant next winner excluding o; hold_cnt=0; preempt=1 for one cycle.
    - If none, o keeps grant, hold_cnt=0, preempt=0.
- Owner release and expiry on the same cycle: treated as release (preempt=0).
- Owner tenure is never more than MAX_HOLD consecutive cycles while others wait.
- MAX_HOLD=1: every grant lasts one cycle when contention exists; strict rotation.
- Invariants: gnt is one-hot or zero; gnt_valid==|gnt; gnt_id matches gnt.
- Reset mid-grant: all outputs drop asynchronously on rst_n fall; arbitration restarts from ptr=0 after release.
- req bits for indices not granted may toggle freely; no req-hold obligation before grant.
- hold_cnt width: $clog2(MAX_HOLD+1); never wraps.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - localparam helper function for index width
- Sub-module rr_pick, combinational:
  - inputs: req[N], ptr[IDW], mask_idx[IDW], mask_en
  - outputs: found, idx[IDW]
  - function: rotate-and-priority-encode; mask_en excludes mask_idx (used for expiry handoff)
- rr_arbiter_ctrl holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Single requester (N=4, MAX_HOLD=4): req=4'b0100 at cycle 0 -> gnt=0100, gnt_id=2 at cycle 1; held indefinitely; hold_cnt restarts every 4 cycles with preempt never asserted.
- Simultaneous start: reset, then req=4'b1111 held -> grants 0,1,2,3,0, each exactly 4 cycles; preempt pulses at each handoff; no idle gaps.
- Release handoff: owner 1, req=4'b1010; drop req[1] at cycle 5 -> gnt=1000 (id 3) at cycle 6, preempt=0; drop req[3] with req=0 -> gnt=0, gnt_valid=0 next cycle.
- Wrap-around: ptr=3 after granting 2; req=4'b1001 -> winner 3, then 0 on release; ptr returns to 1.
- Release + expiry coincident: owner 0 drops req exactly on hold_cnt==3 with req[2]=1 -> gnt=0100 next cycle, preempt=0.
- Async reset mid-grant: assert rst_n=0 between edges while gnt=0010 -> gnt=0, gnt_valid=0, preempt=0 immediately; after release with req=4'b0010, grant to 1 after one cycle, ptr started at 0.
